// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch sequencing: load-use stalls, branch flushes and data-memory wait/timeout FSM.
// Optional stall cycle counter enabled by defining STALL_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dst,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_m_en,
  output logic             m_wb_en,
  output logic             m_wb_bubble,
  output logic             mem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

  localparam logic [TO_W-1:0] ToLast = TO_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            load_use;
  logic            mem_stall;

  assign load_use = ex_mem_read && (ex_dst != 5'd0) &&
                    ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));

  // The first unacknowledged request cycle in RUN is already frozen.
  assign mem_stall = ((state_q == StRun) && mem_access && !mem_ack) ||
                     ((state_q == StMemWait) && !mem_ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StRun;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      StRun: begin
        if (mem_access && !mem_ack) begin
          state_d  = StMemWait;
          to_cnt_d = '0;
        end
      end
      StMemWait: begin
        if (mem_ack) begin
          state_d  = StRun;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_q == ToLast) begin
            state_d = StError;
          end
        end
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d  = StRun;
        to_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    ex_m_en     = 1'b1;
    m_wb_en     = 1'b1;
    m_wb_bubble = 1'b0;
    mem_req     = 1'b0;
    mem_err     = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_en    = 1'b0;
      id_ex_flush = 1'b1;
      ex_m_en     = 1'b0;
      m_wb_en     = 1'b0;
      m_wb_bubble = 1'b1;
    end else begin
      case (state_q)
        StRun, StMemWait: begin
          mem_req = mem_access || (state_q == StMemWait);
          if (mem_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_m_en     = 1'b0;
            m_wb_bubble = 1'b1;
          end else if (branch_taken) begin
            // A coincident load-use is moot: the stalled instruction is squashed.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        default: begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          id_ex_en = 1'b0;
          ex_m_en  = 1'b0;
          m_wb_en  = 1'b0;
          mem_err  = 1'b1;
        end
      endcase
    end
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl; stall_count expectations follow STALL_CNT_EN.
module tb_pipeline_hazard_ctrl;

  localparam logic [9:0] ExpReset  = 10'b0010100100;
  localparam logic [9:0] ExpIdle   = 10'b1101011000;
  localparam logic [9:0] ExpLdUse  = 10'b0001111000;
  localparam logic [9:0] ExpBranch = 10'b1111111000;
  localparam logic [9:0] ExpFrozen = 10'b0000001110;
  localparam logic [9:0] ExpAck    = 10'b1101011010;
  localparam logic [9:0] ExpError  = 10'b0000000001;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_dst;
  logic        id_uses_rt, ex_mem_read, branch_taken, mem_access, mem_ack;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_m_en, m_wb_en, m_wb_bubble, mem_req, mem_err;
  logic [31:0] stall_count;
  logic [9:0]  outs;

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_stall = 0;
  logic [9:0]  exp_q[$];

  always #5 clk = ~clk;

  assign outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                 ex_m_en, m_wb_en, m_wb_bubble, mem_req, mem_err};

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(4),
    .TO_W       (8),
    .CNT_W      (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_dst      (ex_dst),
    .branch_taken(branch_taken),
    .mem_access  (mem_access),
    .mem_ack     (mem_ack),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .if_id_flush (if_id_flush),
    .id_ex_en    (id_ex_en),
    .id_ex_flush (id_ex_flush),
    .ex_m_en     (ex_m_en),
    .m_wb_en     (m_wb_en),
    .m_wb_bubble (m_wb_bubble),
    .mem_req     (mem_req),
    .mem_err     (mem_err),
    .stall_count (stall_count)
  );

  function automatic logic [31:0] exp_cnt();
`ifdef STALL_CNT_EN
    return 32'(exp_stall);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, sample mid-cycle, then advance past the next edge.
  task automatic step(input string tag, input logic rst, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt, input logic mrd,
                      input logic [4:0] dst, input logic br, input logic macc,
                      input logic mack, input logic [9:0] exp);
    logic [9:0] e;
    reset        = rst;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = urt;
    ex_mem_read  = mrd;
    ex_dst       = dst;
    branch_taken = br;
    mem_access   = macc;
    mem_ack      = mack;
    exp_q.push_back(exp);
    if (rst) exp_stall = 0;
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, 32'(outs), 32'(e));
    check({tag, "_cnt"}, stall_count, exp_cnt());
    if (!rst && !e[9]) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    id_rs = '0; id_rt = '0; ex_dst = '0;
    id_uses_rt = 1'b0; ex_mem_read = 1'b0; branch_taken = 1'b0;
    mem_access = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) step("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, ExpReset);
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, ExpIdle);
    step("idle2", 0, 3, 4, 1, 0, 3, 0, 0, 0, ExpIdle);

    step("lu_rs", 0, 5, 0, 0, 1, 5, 0, 0, 0, ExpLdUse);
    step("lu_after", 0, 5, 0, 0, 0, 0, 0, 0, 0, ExpIdle);
    step("lu_dst0", 0, 0, 0, 1, 1, 0, 0, 0, 0, ExpIdle);
    step("lu_rt_unused", 0, 3, 7, 0, 1, 7, 0, 0, 0, ExpIdle);
    step("lu_rt", 0, 3, 7, 1, 1, 7, 0, 0, 0, ExpLdUse);
    step("lu_nomatch", 0, 6, 4, 1, 1, 7, 0, 0, 0, ExpIdle);

    step("br_lu", 0, 3, 7, 1, 1, 7, 1, 0, 0, ExpBranch);
    step("br", 0, 0, 0, 0, 0, 0, 1, 0, 0, ExpBranch);

    step("mem_zw", 0, 0, 0, 0, 0, 0, 0, 1, 1, ExpAck);
    step("mem_zw_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, ExpIdle);

    step("mw_run", 0, 0, 0, 0, 0, 0, 0, 1, 0, ExpFrozen);
    step("mw_br", 0, 3, 7, 1, 1, 7, 1, 1, 0, ExpFrozen);
    step("mw_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0, ExpFrozen);
    step("mw_ack", 0, 0, 0, 0, 0, 0, 0, 1, 1, ExpAck);
    step("mw_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, ExpIdle);

    // Reset in the middle of a wait, between clock edges.
    step("ar_run", 0, 0, 0, 0, 0, 0, 0, 1, 0, ExpFrozen);
    step("ar_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0, ExpFrozen);
    #1;
    check("ar_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    exp_stall = 0;
    #1;
    check("ar_async", 32'(outs), 32'(ExpReset));
    check("ar_async_cnt", stall_count, exp_cnt());
    @(posedge clk);
    #1;
    step("ar_rst", 1, 0, 0, 0, 0, 0, 0, 1, 0, ExpReset);
    step("ar_rel", 0, 0, 0, 0, 0, 0, 0, 0, 0, ExpIdle);

    step("to_run", 0, 0, 0, 0, 0, 0, 0, 1, 0, ExpFrozen);
    for (int i = 0; i < 4; i++) step("to_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0, ExpFrozen);
    step("to_err", 0, 0, 0, 0, 0, 0, 0, 1, 0, ExpError);
    step("to_err_ack", 0, 5, 0, 0, 1, 5, 1, 1, 1, ExpError);
    step("to_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, ExpReset);
    step("to_clr", 0, 0, 0, 0, 0, 0, 0, 0, 0, ExpIdle);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
